// File: rtl/soc_system_pio_pkg.sv
// Purpose: shared register map and edge-type encodings for the PIO slaves.
// Latency: n/a (constants only).
// Backpressure: n/a.
package soc_system_pio_pkg;

    // Avalon word addresses of the edge-capture PIO register file
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_EVCOUNT = 2'd3;

    // Edge-detection selector values for the EDGE_TYPE parameter
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Purpose: WIDTH-bit multi-flop synchroniser for asynchronous inputs.
// Latency: SYNC_STAGES clk cycles from d to q.
// Backpressure: none, samples every cycle.
//
// Ports:
//   clk      - destination clock
//   reset_n  - asynchronous active-low reset, clears every stage
//   d        - asynchronous input bus
//   q        - synchronised output bus (last stage)
module soc_system_pio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Purpose: Avalon-MM input PIO with per-bit edge capture, maskable irq and event counter.
// Latency: reads 1 cycle; in_port edge to EDGECAP/EVCOUNT SYNC_STAGES+1 cycles.
// Backpressure: none, slave accepts every access (no waitrequest).
//
// Ports:
//   clk, reset_n          - clock and asynchronous active-low reset
//   address               - word select: DATA, IRQMASK, EDGECAP (W1C), EVCOUNT (write clears)
//   chipselect, write_n   - write qualifier (chipselect) and active-low write strobe
//   writedata             - write data
//   in_port               - asynchronous external inputs
//   readdata              - registered read data, follows address every cycle
//   irq                   - level interrupt, |(EDGECAP & IRQMASK)
module soc_system_pio_in_edge
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             wr_en;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [CNT_W-1:0] evcount;
    logic [31:0]      rd_next;

    assign wr_en = chipselect & ~write_n;

    soc_system_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_q)
    );

    // prev resets to 0, so an input held high through reset shows up as a
    // rising edge once it has crossed the synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= sync_q;
        end
    end

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_det = sync_q & ~prev;
            EDGE_FALL: edge_det = ~sync_q & prev;
            default:   edge_det = sync_q ^ prev;
        endcase
    end

    assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
            evcount <= '0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // OR-ing the new edges after the clear lets a coincident set win
            edgecap <= (edgecap & ~cap_clr) | edge_det;
            // A clear write takes priority over a same-cycle increment
            if (wr_en && address == ADDR_EVCOUNT) begin
                evcount <= '0;
            end else if (|edge_det && evcount != CNT_MAX) begin
                evcount <= evcount + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
            default:      rd_next[CNT_W-1:0] = evcount;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Purpose: self-checking bench for soc_system_pio_in_edge across three parameter sets.
// Latency: n/a.
// Backpressure: n/a.
module tb_soc_system_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_bus;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // A: rising, 32 bits, 2 stages, 16-bit counter
    soc_system_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_bus),
        .readdata(rd_a), .irq(irq_a));

    // B: falling, 12 bits, 3 stages, 8-bit counter
    soc_system_pio_in_edge #(.WIDTH(12), .SYNC_STAGES(3), .EDGE_TYPE(1), .CNT_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_bus[11:0]),
        .readdata(rd_b), .irq(irq_b));

    // C: any edge, 8 bits, 2 stages, 4-bit counter
    soc_system_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .CNT_W(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_bus[7:0]),
        .readdata(rd_c), .irq(irq_c));

    function automatic int wid(input int i);
        case (i) 0: return 32; 1: return 12; default: return 8; endcase
    endfunction
    function automatic int stg(input int i);
        case (i) 0: return 2; 1: return 3; default: return 2; endcase
    endfunction
    function automatic int ety(input int i);
        case (i) 0: return 0; 1: return 1; default: return 2; endcase
    endfunction
    function automatic int cw(input int i);
        case (i) 0: return 16; 1: return 8; default: return 4; endcase
    endfunction
    function automatic logic [31:0] wmask(input int i);
        logic [63:0] m;
        m = (64'd1 << wid(i)) - 64'd1;
        return m[31:0];
    endfunction

    // Reference model: the value of s seen at a clock edge is the input sampled
    // SYNC_STAGES edges earlier; prev is the one before that.
    logic [31:0] m_hist [3][6];
    logic [31:0] m_cap  [3];
    logic [31:0] m_mask [3];
    logic [31:0] m_rd   [3];
    longint      m_cnt  [3];
    logic        m_irq  [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input logic rst_n, input logic wr,
                              input logic [1:0] a, input logic [31:0] wd, input logic [31:0] in_v);
        logic [31:0] msk, cur, old, e, clr;
        logic [63:0] cmax;
        if (!rst_n) begin
            for (int k = 0; k < 6; k++) m_hist[i][k] = '0;
            m_cap[i]  = '0;
            m_mask[i] = '0;
            m_rd[i]   = '0;
            m_cnt[i]  = 0;
            m_irq[i]  = 1'b0;
        end else begin
            msk = wmask(i);
            cur = m_hist[i][stg(i)-1];
            old = m_hist[i][stg(i)];
            case (ety(i))
                0:       e = cur & ~old;
                1:       e = ~cur & old;
                default: e = cur ^ old;
            endcase
            e = e & msk;
            case (a)
                2'd0:    m_rd[i] = cur;
                2'd1:    m_rd[i] = m_mask[i];
                2'd2:    m_rd[i] = m_cap[i];
                default: m_rd[i] = 32'(m_cnt[i]);
            endcase
            clr = (wr && a == 2'd2) ? (wd & msk) : 32'h0;
            m_cap[i] = (m_cap[i] & ~clr) | e;
            if (wr && a == 2'd1) m_mask[i] = wd & msk;
            cmax = (64'd1 << cw(i)) - 64'd1;
            if (wr && a == 2'd3) m_cnt[i] = 0;
            else if (e != 0 && m_cnt[i] < longint'(cmax)) m_cnt[i] = m_cnt[i] + 1;
            for (int k = 5; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = in_v & msk;
            m_irq[i] = |(m_cap[i] & m_mask[i]);
        end
    endtask

    // Every-cycle comparison of all three DUTs against the model
    always begin : cmp
        logic        s_rst, s_wr;
        logic [1:0]  s_addr;
        logic [31:0] s_wd, s_in;
        @(posedge clk);
        s_rst  = reset_n;
        s_wr   = chipselect && !write_n;
        s_addr = address;
        s_wd   = writedata;
        s_in   = in_bus;
        #1;
        for (int i = 0; i < 3; i++) model_step(i, s_rst, s_wr, s_addr, s_wd, s_in);
        check("model_rd_a", rd_a, m_rd[0]);
        check("model_rd_b", rd_b, m_rd[1]);
        check("model_rd_c", rd_c, m_rd[2]);
        check("model_irq_a", {31'b0, irq_a}, {31'b0, m_irq[0]});
        check("model_irq_b", {31'b0, irq_b}, {31'b0, m_irq[1]});
        check("model_irq_c", {31'b0, irq_c}, {31'b0, m_irq[2]});
    end

    // All driver tasks are entered and left at a negedge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_bus();
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'b1;
        writedata  = $urandom;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    initial begin
        in_bus     = '0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        reset_n    = 1'b1;
        #2 reset_n = 1'b0;
        cyc(3);
        check("reset_rd_a", rd_a, 32'h0);
        check("reset_irq_a", {31'b0, irq_a}, 32'h0);
        reset_n = 1'b1;
        cyc(2);

        // Rising capture and DATA latency
        in_bus  = 32'h0000_00A5;
        address = 2'd0;
        cyc(2);
        check("data_before_edge3", rd_a, 32'h0);
        cyc(1);
        check("data_at_edge3", rd_a, 32'hA5);
        cyc(2);
        rd(2'd2);
        check("edgecap_a_A5", rd_a, 32'hA5);
        check("edgecap_b_none", rd_b, 32'h0);
        rd(2'd3);
        check("evcount_a_1", rd_a, 32'h1);
        check("irq_a_unmasked", {31'b0, irq_a}, 32'h0);

        // Mask then clear
        wr(2'd1, 32'h1);
        check("irq_after_mask", {31'b0, irq_a}, 32'h1);
        wr(2'd2, 32'h1);
        check("irq_after_clear", {31'b0, irq_a}, 32'h0);
        rd(2'd2);
        check("edgecap_a_A4", rd_a, 32'hA4);

        // Clear of bit 1 coincident with its rising edge: set wins
        wr(2'd1, 32'h2);
        in_bus = 32'h0000_00A7;
        cyc(2);
        wr(2'd2, 32'h2);
        rd(2'd2);
        check("set_wins_cap", rd_a, 32'hA6);
        check("set_wins_irq", {31'b0, irq_a}, 32'h1);

        // Saturation of the 4-bit counter on the any-edge instance
        for (int n = 0; n < 20; n++) begin
            in_bus = in_bus ^ 32'h1;
            cyc(4);
        end
        rd(2'd3);
        check("evcount_c_sat", rd_c, 32'hF);
        in_bus = in_bus ^ 32'h1;
        cyc(2);
        wr(2'd3, $urandom);
        rd(2'd3);
        check("evcount_c_clear_wins", rd_c, 32'h0);

        // Falling capture on B, then short pulses on bit 8
        in_bus = 32'h0000_00FF;
        cyc(8);
        wr(2'd2, 32'hFFFF_FFFF);
        in_bus = 32'h0000_000F;
        cyc(8);
        rd(2'd2);
        check("edgecap_b_fall", rd_b, 32'hF0);
        in_bus = 32'h0000_010F;
        cyc(8);
        wr(2'd2, 32'hFFFF_FFFF);
        in_bus = 32'h0000_000F;
        cyc(1);
        in_bus = 32'h0000_010F;
        cyc(8);
        wr(2'd2, 32'hFFFF_FFFF);
        in_bus = 32'h0000_000F;
        cyc(2);
        in_bus = 32'h0000_010F;
        cyc(8);
        rd(2'd2);
        check("edgecap_b_pulse2", rd_b, 32'h100);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) in_bus = $urandom;
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                writedata  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
            end else begin
                idle_bus();
                write_n = 1'($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                if (!write_n) chipselect = 1'b0;
            end
            @(negedge clk);
        end
        idle_bus();

        // Input held high through reset release
        reset_n = 1'b0;
        in_bus  = 32'h1;
        cyc(2);
        check("rst_hold_rd_a", rd_a, 32'h0);
        address = 2'd2;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_hold_cap_edge3", rd_a, 32'h0);
        @(posedge clk);
        #2;
        check("rst_hold_cap_edge4", rd_a, 32'h1);
        @(negedge clk);

        // Reset in the middle of counting
        for (int n = 0; n < 5; n++) begin
            in_bus = in_bus ^ 32'h1;
            cyc(3);
        end
        reset_n = 1'b0;
        in_bus  = '0;
        cyc(1);
        check("midrst_irq_a", {31'b0, irq_a}, 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            check("midrst_rd_a", rd_a, 32'h0);
            check("midrst_rd_c", rd_c, 32'h0);
        end

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_system_pio_in_edge.md
# soc_system_pio_in_edge

Parametrised Avalon-MM input PIO slave, successor to the plain read-only input port. It synchronises a WIDTH-bit asynchronous input bus into the clk domain and detects per-bit edges into a sticky, write-one-to-clear capture register. It raises a maskable level interrupt and keeps a saturating count of edge events. It sits on the HPS lightweight bridge alongside the existing PIO slaves, feeding a GIC interrupt line.

## Interface
- WIDTH, 32: input bus width, 1..32; readdata bits above WIDTH-1 read 0.
- SYNC_STAGES, 2: synchroniser depth, 2..4.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge.
- CNT_W, 16: event counter width, 1..32.

Ports:
- clk  in  1  single clock; all state on posedge clk.
- reset_n  in  1  asynchronous, active-low reset; resets all state.
- address  in  2  register select.
- chipselect  in  1  slave select, qualifies writes only.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.

## Operation
Register map (word addresses):
- 0 DATA (RO): synchronised input, zero-extended; writes ignored.
- 1 IRQMASK (RW): bits WIDTH-1:0 stored, upper bits ignored and read 0.
- 2 EDGECAP (RW1C): sticky per-bit edge flags; write 1 clears that bit, write 0 no effect.
- 3 EVCOUNT (R, write-any clears): number of cycles in which at least one edge was detected; saturates at 2^CNT_W-1.

Behaviour:
- Write occurs when chipselect=1 and write_n=0 at posedge clk.
- in_port passes through a SYNC_STAGES-deep flop chain (sync output = s); one further flop holds prev.
- edge[i]: rising = s & ~prev; falling = ~s & prev; any = s ^ prev.
- EDGECAP <= (EDGECAP & ~clr) | edge, where clr = writedata bits on a write to address 2. A set and a clear of the same bit in the same cycle: set wins, the bit stays 1.
- EVCOUNT increments by 1 in any cycle where |edge = 1, regardless of IRQMASK, and holds at all-ones once saturated. A write to address 3 in the same cycle as an increment: clear wins, the result is 0.
- irq = |(EDGECAP & IRQMASK), derived from registers only, with no added latency.
- readdata <= mux(address) every cycle; it does not depend on chipselect. There is no read side effect.

Reset values:
- All sync flops, prev, IRQMASK, EDGECAP and EVCOUNT reset to 0; readdata = 0; irq = 0.
- Because prev resets to 0, an input already high at reset release registers as a rising edge (EDGE_TYPE 0 or 2) once it reaches s. This is intended.

## Timing
- Read latency is 1 cycle: readdata reflects the address presented at edge N after edge N.
- in_port change settling before edge 1 (SYNC_STAGES=2):
  - s updates after edge 2; DATA read at edge 3 shows it.
  - edge is asserted between edges 2 and 3.
  - EDGECAP and EVCOUNT update at edge 3; irq rises after edge 3 if masked in.
- General: capture latency = SYNC_STAGES+1 cycles.
- Pulses shorter than one clk period may be missed. Pulses of 2 cycles or more are guaranteed to be captured.
- An IRQMASK write takes effect on irq the cycle after the write edge.
- irq deasserts the cycle after an EDGECAP clear, unless a new edge sets the bit in that same cycle.
- Reset asserted mid-operation clears all state immediately (asynchronously); no edge is generated by the reset itself.

## Structure
- Shared package soc_system_pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=2, ADDR_EVCOUNT=3;
  - EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, soc_system_pio_sync: a parametrised WIDTH × SYNC_STAGES synchroniser with asynchronous reset, reusable by the other PIO slaves.

## Test plan
- Reset with in_port=0, then in_port=32'h0000_00A5 (EDGE_TYPE=0) → DATA reads 0xA5 at read edge 3; EDGECAP=0xA5; EVCOUNT=1; irq=0 with IRQMASK=0.
- Write IRQMASK=0x01, then write EDGECAP=0x01 → irq rises the cycle after the mask write and falls the cycle after the clear; EDGECAP=0xA4.
- Write EDGECAP=0x02 in the same cycle a rising edge on bit 1 is detected → bit 1 stays set and irq remains consistent with IRQMASK.
- CNT_W=4, toggle bit 0 twenty times at 4-cycle spacing with EDGE_TYPE=2 → EVCOUNT saturates at 0xF. Write address 3 coincident with an edge → EVCOUNT=0.
- EDGE_TYPE=1, in_port 0xFF→0x0F → EDGECAP=0xF0; a 1-cycle pulse on bit 8 is not required to be captured, while a 2-cycle pulse is.
- Hold in_port=0x1 through reset and release → EDGECAP bit 0 is set SYNC_STAGES+1 cycles after release. Assert reset_n mid-count → all registers read 0 on the following read.
